// File: rtl/ps2_pkg.sv
// Shared PS/2 constants: prefix bytes, ignored keyboard replies, receiver states.
// Latency: none (declarations only).
// Backpressure: not applicable.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT        = 8'hE0;
    localparam logic [7:0] PS2_BRK        = 8'hF0;
    localparam logic [7:0] PS2_PAUSE      = 8'hE1;
    localparam logic [2:0] PS2_PAUSE_SKIP = 3'd7;

    // Keyboard self-test, ack, echo, resend and error replies; never key events.
    localparam logic [7:0] PS2_IGNORED [6] = '{8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RECV = 1'b1
    } rx_state_e;

    function automatic logic is_ignored(input logic [7:0] b);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (b == PS2_IGNORED[i]) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/ps2_scancode_if.sv
// Key-event bus from the scancode front end into the key matrix stage.
// Latency: none (wires only).
// Backpressure: none; the matrix must accept every strb pulse.
interface ps2_scancode_if;
    logic       strb;
    logic       make;
    logic [7:0] code;
    logic       extd;

    modport master (output strb, output make, output code, output extd);
    modport slave  (input  strb, input  make, input  code, input  extd);
endinterface

// File: rtl/ps2_rx.sv
// PS/2 receiver: synchronise, deglitch, deserialise 11-bit frames, check parity.
// Latency: byte_rdy_o one cycle after the fall that samples the stop bit.
// Backpressure: none; a byte is presented for one cycle and must be taken.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int          FILTER  = 8,
    parameter logic [15:0] TIMEOUT = 16'd50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2Ck,
    input  logic       ps2D,
    output logic       byte_rdy_o,
    output logic [7:0] byte_o,
    output logic       err_o
);

    localparam int            FW        = $clog2(FILTER + 1);
    localparam logic [FW-1:0] FILT_LAST = FW'(FILTER - 1);

    logic [1:0]    ck_sync_q;
    logic [1:0]    d_sync_q;
    logic          ck_filt_q;
    logic [FW-1:0] filt_cnt_q;
    logic [15:0]   to_cnt_q;
    logic          fall;
    logic          timed_out;

    rx_state_e     state_q, state_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [9:0]    sh_q, sh_d;
    logic [7:0]    byte_q, byte_d;
    logic          byte_rdy_q, byte_rdy_d;
    logic          err_q, err_d;

    // Two-flop synchronisers; reset to the idle-high bus level.
    always_ff @(posedge clock) begin
        if (reset) begin
            ck_sync_q <= 2'b11;
            d_sync_q  <= 2'b11;
        end else begin
            ck_sync_q <= {ck_sync_q[0], ps2Ck};
            d_sync_q  <= {d_sync_q[0], ps2D};
        end
    end

    // Accept a new clock level only after FILTER consecutive differing samples.
    always_ff @(posedge clock) begin
        if (reset) begin
            ck_filt_q  <= 1'b1;
            filt_cnt_q <= '0;
        end else if (ck_sync_q[1] == ck_filt_q) begin
            filt_cnt_q <= '0;
        end else if (filt_cnt_q == FILT_LAST) begin
            ck_filt_q  <= ck_sync_q[1];
            filt_cnt_q <= '0;
        end else begin
            filt_cnt_q <= filt_cnt_q + FW'(1);
        end
    end

    // Falling edge is the cycle in which the filtered level drops.
    assign fall = ck_filt_q & ~ck_sync_q[1] & (filt_cnt_q == FILT_LAST);

    // Saturating count of cycles since the last falling edge.
    always_ff @(posedge clock) begin
        if (reset || fall) begin
            to_cnt_q <= '0;
        end else if (to_cnt_q != 16'hFFFF) begin
            to_cnt_q <= to_cnt_q + 16'd1;
        end
    end

    assign timed_out = (state_q == RECV) && (to_cnt_q >= TIMEOUT);

    // Shift bits in LSB first; after the stop bit sh_q = {parity, d7..d0, start}.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        sh_d       = sh_q;
        byte_d     = byte_q;
        byte_rdy_d = 1'b0;
        err_d      = 1'b0;
        if (fall) begin
            sh_d = {d_sync_q[1], sh_q[9:1]};
            if (bit_cnt_q == 4'd10) begin
                state_d   = IDLE;
                bit_cnt_d = 4'd0;
                if (!sh_q[0] && d_sync_q[1] && (^sh_q[9:1])) begin
                    byte_rdy_d = 1'b1;
                    byte_d     = sh_q[8:1];
                end else begin
                    err_d = 1'b1;
                end
            end else begin
                state_d   = RECV;
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end else if (timed_out) begin
            state_d   = IDLE;
            bit_cnt_d = 4'd0;
            err_d     = 1'b1;
        end
    end

    // Receiver state registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 4'd0;
            sh_q       <= '0;
            byte_q     <= 8'h00;
            byte_rdy_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            sh_q       <= sh_d;
            byte_q     <= byte_d;
            byte_rdy_q <= byte_rdy_d;
            err_q      <= err_d;
        end
    end

    assign byte_rdy_o = byte_rdy_q;
    assign byte_o     = byte_q;
    assign err_o      = err_q;

endmodule

// File: rtl/ps2_scancode.sv
// PS/2 keyboard front end: strips E0/F0/E1 prefixes, emits one strobe per key event.
// Latency: strb one cycle after the receiver's byte-ready pulse.
// Backpressure: none; events are at least one PS/2 frame apart.
module ps2_scancode
    import ps2_pkg::*;
#(
    parameter int          FILTER  = 8,
    parameter logic [15:0] TIMEOUT = 16'd50000
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            ps2Ck,
    input  logic            ps2D,
    ps2_scancode_if.master  ev
);

    logic       byte_rdy;
    logic [7:0] rx_byte;
    logic       rx_err;

    logic       strb_q, strb_d;
    logic       make_q, make_d;
    logic [7:0] code_q, code_d;
    logic       extd_q, extd_d;
    logic       ext_flag_q, ext_flag_d;
    logic       brk_flag_q, brk_flag_d;
    logic [2:0] skip_q, skip_d;

    ps2_rx #(
        .FILTER  (FILTER),
        .TIMEOUT (TIMEOUT)
    ) u_rx (
        .clock      (clock),
        .reset      (reset),
        .ps2Ck      (ps2Ck),
        .ps2D       (ps2D),
        .byte_rdy_o (byte_rdy),
        .byte_o     (rx_byte),
        .err_o      (rx_err)
    );

    // Prefix decoder; an active pause skip swallows bytes before any other rule.
    always_comb begin
        strb_d     = 1'b0;
        make_d     = make_q;
        code_d     = code_q;
        extd_d     = extd_q;
        ext_flag_d = ext_flag_q;
        brk_flag_d = brk_flag_q;
        skip_d     = skip_q;
        if (rx_err) begin
            ext_flag_d = 1'b0;
            brk_flag_d = 1'b0;
        end else if (byte_rdy) begin
            if (skip_q != 3'd0) begin
                skip_d = skip_q - 3'd1;
            end else if (rx_byte == PS2_EXT) begin
                ext_flag_d = 1'b1;
            end else if (rx_byte == PS2_BRK) begin
                brk_flag_d = 1'b1;
            end else if (rx_byte == PS2_PAUSE) begin
                skip_d = PS2_PAUSE_SKIP;
            end else if (is_ignored(rx_byte)) begin
                ext_flag_d = 1'b0;
                brk_flag_d = 1'b0;
            end else begin
                strb_d     = 1'b1;
                code_d     = rx_byte;
                make_d     = brk_flag_q;
                extd_d     = ext_flag_q;
                ext_flag_d = 1'b0;
                brk_flag_d = 1'b0;
            end
        end
    end

    // Output and flag registers; make idles high (no key pressed).
    always_ff @(posedge clock) begin
        if (reset) begin
            strb_q     <= 1'b0;
            make_q     <= 1'b1;
            code_q     <= 8'h00;
            extd_q     <= 1'b0;
            ext_flag_q <= 1'b0;
            brk_flag_q <= 1'b0;
            skip_q     <= 3'd0;
        end else begin
            strb_q     <= strb_d;
            make_q     <= make_d;
            code_q     <= code_d;
            extd_q     <= extd_d;
            ext_flag_q <= ext_flag_d;
            brk_flag_q <= brk_flag_d;
            skip_q     <= skip_d;
        end
    end

    assign ev.strb = strb_q;
    assign ev.make = make_q;
    assign ev.code = code_q;
    assign ev.extd = extd_q;

endmodule

// File: tb/tb_ps2_scancode.sv
// Bench for ps2_scancode: directed PS/2 frames, expected events queued, monitor compares.
// Latency: not applicable.
// Backpressure: not applicable.
module tb_ps2_scancode;

    localparam int          HALF    = 20;
    localparam int          GAP     = 60;
    localparam logic [15:0] TMO     = 16'd400;

    typedef struct {
        logic [7:0] code;
        logic       make;
        logic       extd;
    } ev_t;

    logic clock;
    logic reset;
    logic ps2Ck;
    logic ps2D;

    int   n_cmp;
    int   n_fail;
    ev_t  exp_q[$];

    ps2_scancode_if ev ();

    ps2_scancode #(
        .FILTER  (8),
        .TIMEOUT (TMO)
    ) dut (
        .clock (clock),
        .reset (reset),
        .ps2Ck (ps2Ck),
        .ps2D  (ps2D),
        .ev    (ev)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic expect_ev(input logic [7:0] c, input logic m, input logic x);
        ev_t e;
        e.code = c;
        e.make = m;
        e.extd = x;
        exp_q.push_back(e);
    endtask

    // One PS/2 bit: data set while clock high, optional 3-cycle low glitch, then a real fall.
    task automatic ps2_bit(input logic b, input bit glitch);
        ps2D = b;
        if (glitch) begin
            wait_cyc(6);
            ps2Ck = 1'b0;
            wait_cyc(3);
            ps2Ck = 1'b1;
            wait_cyc(HALF - 9);
        end else begin
            wait_cyc(HALF);
        end
        ps2Ck = 1'b0;
        wait_cyc(HALF);
        ps2Ck = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit flip_par, input int nbits, input bit glitch);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ flip_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(f[i], glitch);
        ps2D = 1'b1;
        wait_cyc(GAP);
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b0, 11, 1'b0);
    endtask

    task automatic check_out(input string name, input logic s, input logic m,
                             input logic [7:0] c, input logic x);
        n_cmp++;
        if ({ev.strb, ev.make, ev.code, ev.extd} !== {s, m, c, x}) begin
            n_fail++;
            $display("FAIL %s: got strb=%b make=%b code=%h extd=%b, wanted strb=%b make=%b code=%h extd=%b",
                     name, ev.strb, ev.make, ev.code, ev.extd, s, m, c, x);
        end
    endtask

    task automatic check_drain(input string name);
        wait_cyc(40);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: %0d expected events never strobed, wanted 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic pulse_reset(input string name);
        reset = 1'b1;
        wait_cyc(1);
        check_out(name, 1'b0, 1'b1, 8'h00, 1'b0);
        reset = 1'b0;
    endtask

    // Monitor: every strobe must match the oldest queued event.
    initial begin
        ev_t e;
        forever begin
            @(negedge clock);
            if (ev.strb === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL strb_unexpected: got code=%h make=%b extd=%b, wanted no event",
                             ev.code, ev.make, ev.extd);
                end else begin
                    e = exp_q.pop_front();
                    if ({ev.code, ev.make, ev.extd} !== {e.code, e.make, e.extd}) begin
                        n_fail++;
                        $display("FAIL event: got code=%h make=%b extd=%b, wanted code=%h make=%b extd=%b",
                                 ev.code, ev.make, ev.extd, e.code, e.make, e.extd);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, wanted end of stimulus");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        ps2Ck  = 1'b1;
        ps2D   = 1'b1;
        reset  = 1'b1;
        wait_cyc(3);
        check_out("reset_state", 1'b0, 1'b1, 8'h00, 1'b0);
        reset = 1'b0;
        wait_cyc(20);

        // Plain make then break of 1C.
        expect_ev(8'h1C, 1'b0, 1'b0);
        send(8'h1C);
        expect_ev(8'h1C, 1'b1, 1'b0);
        send(8'hF0);
        send(8'h1C);
        check_drain("make_break_1c");
        check_out("hold_1c", 1'b0, 1'b1, 8'h1C, 1'b0);

        // Extended make/break, then plain 75 clears extd.
        expect_ev(8'h75, 1'b0, 1'b1);
        send(8'hE0);
        send(8'h75);
        expect_ev(8'h75, 1'b1, 1'b1);
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        expect_ev(8'h75, 1'b0, 1'b0);
        send(8'h75);
        check_drain("extended_75");

        // Bad parity dropped, next good frame accepted.
        send_frame(8'h1C, 1'b1, 11, 1'b0);
        expect_ev(8'h16, 1'b0, 1'b0);
        send(8'h16);
        check_drain("parity_error");

        // Pause sequence swallowed whole.
        send(8'hE1);
        send(8'h14);
        send(8'h77);
        send(8'hE1);
        send(8'hF0);
        send(8'h14);
        send(8'hF0);
        send(8'h77);
        check_out("pause_no_event", 1'b0, 1'b0, 8'h16, 1'b0);
        expect_ev(8'h29, 1'b0, 1'b0);
        send(8'h29);
        check_drain("pause_then_29");

        // Aborted frame recovered by timeout.
        send_frame(8'h5A, 1'b0, 5, 1'b0);
        wait_cyc(int'(TMO) + 100);
        expect_ev(8'h5A, 1'b0, 1'b0);
        send(8'h5A);
        check_drain("timeout_5a");

        // Short clock glitches inside every bit must not shift bits.
        expect_ev(8'h4B, 1'b0, 1'b0);
        send_frame(8'h4B, 1'b0, 11, 1'b1);
        check_drain("glitch_4b");
        check_out("hold_4b", 1'b0, 1'b0, 8'h4B, 1'b0);

        // Reset after F0 and mid-frame; break flag and partial frame discarded.
        send(8'hF0);
        pulse_reset("reset_after_f0");
        wait_cyc(10);
        send_frame(8'h33, 1'b0, 5, 1'b0);
        pulse_reset("reset_mid_frame");
        wait_cyc(20);
        expect_ev(8'h24, 1'b0, 1'b0);
        send(8'h24);
        check_drain("after_reset_24");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
